// File: rtl/mfc_frame_tx.sv
// MFCC frame transmitter: ping-pong frame buffer, energy VAD with hangover,
// burst serialiser. Ports: clk, reset (async, active-low), coef_in/coef_dv/
// coef_first in; vec_o/dv_o/sof_o/vad_o out, ovf_o/err_o sticky flags.
module mfc_frame_tx #(
  parameter int BIT    = 32,
  parameter int NCOEF  = 12,
  parameter int THRESH = 0,
  parameter int HANG   = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BIT-1:0] coef_in,
  input  logic           coef_dv,
  input  logic           coef_first,
  output logic [BIT-1:0] vec_o,
  output logic           dv_o,
  output logic           sof_o,
  output logic           vad_o,
  output logic           ovf_o,
  output logic           err_o
);

  localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int RW = $clog2(NCOEF + 1);
  localparam int HW = (HANG > 0) ? $clog2(HANG + 1) : 1;
  localparam logic signed [BIT-1:0] TH = BIT'(THRESH);
  localparam logic [IW-1:0] LAST = IW'(NCOEF - 1);
  localparam logic [HW-1:0] HMAX = HW'(HANG);
  localparam logic [RW-1:0] RDONE = RW'(NCOEF);

  typedef enum logic {IDLE, ACTIVE} vad_t;
  typedef enum logic {TIDLE, TSEND} tx_t;

  logic [BIT-1:0] mem [2][NCOEF];
  logic [1:0]     full;

  logic [IW-1:0]  wi;
  logic           wb;
  logic           fb;
  logic           drop;
  logic           done;
  logic [BIT-1:0] c0;

  vad_t           vstate, vnext;
  logic [HW-1:0]  hang, hnext;
  logic           accept;

  tx_t            tstate, tnext;
  logic [RW-1:0]  ri, rnext;
  logic           rb, rbnext;
  logic           rel;
  logic [BIT-1:0] vecn;
  logic           dvn, sofn;

  logic start, cont, stray, last;
  logic tgt, tgt_free;

  assign start = coef_dv & coef_first;
  assign cont  = coef_dv & ~coef_first & (wi != '0);
  assign stray = coef_dv & ~coef_first & (wi == '0);
  assign last  = cont & (wi == LAST);

  // A frame opening while the previous one is being accepted goes
  // to the bank the pointer is about to toggle to.
  assign tgt      = accept ? ~wb : wb;
  assign tgt_free = ~full[tgt] | (rel & (rb == tgt));

  always_ff @(posedge clk) begin
    if (start && tgt_free) mem[tgt][0] <= coef_in;
    if (cont && !drop)     mem[fb][wi] <= coef_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wi    <= '0;
      wb    <= 1'b0;
      fb    <= 1'b0;
      drop  <= 1'b0;
      done  <= 1'b0;
      c0    <= '0;
      ovf_o <= 1'b0;
      err_o <= 1'b0;
      full  <= 2'b00;
    end else begin
      done <= last & ~drop;
      if (start) begin
        wi   <= IW'(1);
        fb   <= tgt;
        drop <= ~tgt_free;
        c0   <= coef_in;
        if (wi != '0) err_o <= 1'b1;
        if (!tgt_free) ovf_o <= 1'b1;
      end else if (cont) begin
        wi <= last ? '0 : wi + IW'(1);
      end
      if (stray) err_o <= 1'b1;
      if (accept) wb <= ~wb;
      for (int b = 0; b < 2; b++) begin
        full[b] <= (full[b] & ~(rel & (rb == b[0])))
                 | (accept & (wb == b[0]));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vstate <= IDLE;
      hang   <= '0;
    end else begin
      vstate <= vnext;
      hang   <= hnext;
    end
  end

  always_comb begin
    vnext  = vstate;
    hnext  = hang;
    accept = 1'b0;
    if (done) begin
      unique case (vstate)
        IDLE: begin
          if ($signed(c0) > TH) begin
            vnext  = ACTIVE;
            hnext  = HMAX;
            accept = 1'b1;
          end
        end
        ACTIVE: begin
          if ($signed(c0) > TH) begin
            hnext  = HMAX;
            accept = 1'b1;
          end else if (hang != '0) begin
            hnext  = hang - HW'(1);
            accept = 1'b1;
          end else begin
            vnext = IDLE;
          end
        end
      endcase
    end
  end

  assign vad_o = (vstate == ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tstate <= TIDLE;
      ri     <= '0;
      rb     <= 1'b0;
      vec_o  <= '0;
      dv_o   <= 1'b0;
      sof_o  <= 1'b0;
    end else begin
      tstate <= tnext;
      ri     <= rnext;
      rb     <= rbnext;
      vec_o  <= vecn;
      dv_o   <= dvn;
      sof_o  <= sofn;
    end
  end

  // ri == RDONE marks "last element just sent": a pending bank can
  // start on the very next edge so bursts run back to back.
  always_comb begin
    tnext  = tstate;
    rnext  = ri;
    rbnext = rb;
    vecn   = vec_o;
    dvn    = 1'b0;
    sofn   = 1'b0;
    rel    = 1'b0;
    if ((tstate == TIDLE || ri == RDONE) && full[rb]) begin
      tnext = TSEND;
      rnext = RW'(1);
      vecn  = mem[rb][0];
      dvn   = 1'b1;
      sofn  = 1'b1;
    end else if (tstate == TSEND && ri != RDONE) begin
      vecn  = mem[rb][ri[IW-1:0]];
      dvn   = 1'b1;
      rnext = ri + RW'(1);
      if (ri[IW-1:0] == LAST) begin
        rel    = 1'b1;
        rbnext = ~rb;
      end
    end else begin
      tnext = TIDLE;
    end
  end

endmodule

// File: tb/tb_mfc_frame_tx.sv
// Scoreboard bench for mfc_frame_tx (NCOEF=4, THRESH=100, HANG=2).
// Driver models VAD/burst timing; monitor compares every dv_o cycle.
module tb_mfc_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] coef_in;
  logic        coef_dv, coef_first;
  logic [31:0] vec_o;
  logic        dv_o, sof_o, vad_o, ovf_o, err_o;

  mfc_frame_tx #(.BIT(32), .NCOEF(4), .THRESH(100), .HANG(2)) dut (
    .clk(clk), .reset(reset),
    .coef_in(coef_in), .coef_dv(coef_dv), .coef_first(coef_first),
    .vec_o(vec_o), .dv_o(dv_o), .sof_o(sof_o), .vad_o(vad_o),
    .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint cyc; logic [31:0] val; logic sof; } exp_t;
  typedef struct { longint cyc; logic vad; } vexp_t;

  exp_t   dq[$];
  vexp_t  vq[$];
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     run = 0;
  int     maxrun = 0;

  bit     m_act = 0;
  int     m_hang = 0;
  longint m_end = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (dv_o) begin
        run++;
        if (dq.size() == 0) begin
          chk("dv_unexpected", 1'b0, $signed(vec_o), 0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          chk("burst_cycle", e.cyc == cyc, cyc, e.cyc);
          chk("vec", vec_o == e.val, $signed(vec_o), $signed(e.val));
          chk("sof", sof_o == e.sof, sof_o, e.sof);
        end
      end else begin
        if (run > maxrun) maxrun = run;
        run = 0;
        if (sof_o) chk("sof_without_dv", 1'b0, 1, 0);
      end
      while (dq.size() != 0 && dq[0].cyc < cyc) begin
        exp_t e;
        e = dq.pop_front();
        chk("dv_missing", 1'b0, 0, e.cyc);
      end
      if (vq.size() != 0 && vq[0].cyc <= cyc) begin
        vexp_t v;
        v = vq.pop_front();
        chk("vad", vad_o == v.vad && v.cyc == cyc, vad_o, v.vad);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      coef_dv = 1'b0;
      coef_first = 1'b0;
    end
  endtask

  task automatic drive(input int val, input bit first);
    @(posedge clk); #1;
    coef_in = val;
    coef_dv = 1'b1;
    coef_first = first;
  endtask

  // Reference: VAD rules applied per completed frame; a burst starts two
  // edges after the last coefficient or right after the previous burst.
  task automatic model_done(input int v[4], input longint t);
    bit acc;
    bit sp;
    longint st;
    sp = v[0] > 100;
    acc = 0;
    if (!m_act) begin
      if (sp) begin m_act = 1; m_hang = 2; acc = 1; end
    end else if (sp) begin
      m_hang = 2; acc = 1;
    end else if (m_hang > 0) begin
      m_hang--; acc = 1;
    end else begin
      m_act = 0;
    end
    vq.push_back('{t + 1, m_act});
    if (acc) begin
      st = (t + 2 > m_end + 1) ? t + 2 : m_end + 1;
      for (int i = 0; i < 4; i++)
        dq.push_back('{st + i, 32'(v[i]), i == 0});
      m_end = st + 3;
    end
  endtask

  task automatic send_frame(input int a, input int b, input int c,
                            input int d, input int gmax);
    int v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (gmax > 0) idle($urandom_range(gmax));
      drive(v[i], i == 0);
    end
    model_done(v, cyc + 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((dq.size() != 0 || vq.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", dq.size() == 0 && vq.size() == 0,
        dq.size() + vq.size(), 0);
    idle(3);
  endtask

  initial begin
    longint st;
    int k;
    reset = 1'b0;
    coef_in = '0;
    coef_dv = 1'b0;
    coef_first = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dv", dv_o == 0, dv_o, 0);
    chk("rst_sof", sof_o == 0, sof_o, 0);
    chk("rst_vad", vad_o == 0, vad_o, 0);
    chk("rst_ovf", ovf_o == 0, ovf_o, 0);
    chk("rst_err", err_o == 0, err_o, 0);
    chk("rst_vec", vec_o == 0, vec_o, 0);
    reset = 1'b1;
    idle(2);

    send_frame(200, 1, 2, 3, 0);
    idle(1);
    drain();

    send_frame(200, 11, 12, 13, 0);
    for (int f = 0; f < 4; f++) send_frame(50, 20 + f, 30 + f, 40 + f, 0);
    idle(1);
    drain();
    chk("hang_vad_low", vad_o == 0, vad_o, 0);

    send_frame(-5, 1, 1, 1, 0);
    send_frame(100, 2, 2, 2, 0);
    idle(1);
    drain();
    chk("quiet_vad", vad_o == 0, vad_o, 0);
    send_frame(101, 5, 6, 7, 0);
    idle(1);
    drain();

    maxrun = 0;
    for (int f = 0; f < 6; f++)
      send_frame(300 + f, f * 10 + 1, f * 10 + 2, f * 10 + 3, 0);
    idle(1);
    drain();
    chk("fullrate_run", maxrun == 24, maxrun, 24);
    chk("fullrate_ovf", ovf_o == 0, ovf_o, 0);
    chk("err_clean", err_o == 0, err_o, 0);

    drive(200, 1);
    drive(7, 0);
    send_frame(300, 4, 5, 6, 0);
    idle(1);
    drain();
    chk("framing_err", err_o == 1, err_o, 1);

    for (int f = 0; f < 30; f++) begin
      int a;
      a = int'($urandom_range(600)) - 300;
      send_frame(a, int'($urandom), int'($urandom), int'($urandom), 2);
    end
    idle(1);
    drain();
    chk("random_ovf", ovf_o == 0, ovf_o, 0);

    send_frame(250, 9, 8, 7, 0);
    idle(1);
    st = m_end - 3;
    k = 0;
    while (cyc < st + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("burst_reach", cyc == st + 2, cyc, st + 2);
    #2;
    reset = 1'b0;
    dq.delete();
    vq.delete();
    m_act = 0;
    m_hang = 0;
    m_end = -10;
    #1;
    chk("midrst_dv", dv_o == 0, dv_o, 0);
    chk("midrst_vad", vad_o == 0, vad_o, 0);
    chk("midrst_err", err_o == 0, err_o, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(10);
    send_frame(400, 3, 2, 1, 0);
    idle(1);
    drain();

    chk("err_after_rst", err_o == 0, err_o, 0);
    drive(55, 0);
    idle(3);
    chk("stray_err", err_o == 1, err_o, 1);
    drain();
    chk("final_ovf", ovf_o == 0, ovf_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
